// File: rtl/fetch_unit.sv
// Sequential-PC fetch stage: credit-limited imem requests, in-order response
// queue toward the decoder, redirect flush with stale-response dropping.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            o_imem_req_valid,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_req_ready,
  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rsp_data,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  input  logic            i_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic            run_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [XLEN-1:0] ins_mem [DEPTH];
  logic [XLEN-1:0] pcs_mem [DEPTH];

  logic            credit;
  logic            req_fire;
  logic            rsp_fire;
  logic            keep;
  logic            deq;
  logic [XLEN-1:0] tgt;

  assign tgt      = i_redirect_pc & ~XLEN'(3);
  assign credit   = ({1'b0, out_q} + {1'b0, cnt_q}) < DEPTH_W;

  // run_q holds requests off while reset is asserted.
  assign o_imem_req_valid = run_q && !i_redirect_valid && credit;
  assign o_imem_req_addr  = pc_q;

  assign req_fire = o_imem_req_valid && i_imem_req_ready;
  assign rsp_fire = i_imem_rsp_valid;
  assign keep     = rsp_fire && (drop_q == '0) && !i_redirect_valid;

  assign o_valid  = (cnt_q != '0) && !i_redirect_valid;
  assign o_instr  = ins_mem[rd_q];
  assign o_pc     = pcs_mem[rd_q];
  assign deq      = o_valid && i_ready;

  always_comb begin
    pc_d   = pc_q;
    rpc_d  = rpc_q;
    drop_d = drop_q;
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    out_d  = out_q + CW'(req_fire) - CW'(rsp_fire);
    if (i_redirect_valid) begin
      pc_d   = tgt;
      rpc_d  = tgt;
      // Every in-flight request is stale, including ones already marked.
      drop_d = out_q - CW'(rsp_fire);
      cnt_d  = '0;
      rd_d   = '0;
      wr_d   = '0;
    end else begin
      if (req_fire)
        pc_d = pc_q + XLEN'(4);
      if (rsp_fire && (drop_q != '0))
        drop_d = drop_q - CW'(1);
      if (keep) begin
        rpc_d = rpc_q + XLEN'(4);
        wr_d  = wr_q + PW'(1);
      end
      if (deq)
        rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(keep) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      pc_q   <= RESET_PC;
      rpc_q  <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
    end else begin
      run_q  <= 1'b1;
      pc_q   <= pc_d;
      rpc_q  <= rpc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (keep) begin
      ins_mem[wr_q] <= i_imem_rsp_data;
      pcs_mem[wr_q] <= rpc_q;
    end
  end

endmodule
